// File: rtl/ifu_fetch_buf.sv
// Instruction fetch front end: sequential PC generation, credit-limited
// requests to instruction memory, and an in-order show-ahead buffer that
// feeds decode with {instr, tag=PC}.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   imem_req_valid     fetch request valid (combinational from credit/flush)
//   imem_req_ready     memory accepts request this cycle
//   imem_req_addr      fetch address (current PC)
//   imem_rsp_valid     in-order response valid, latency >= 1
//   imem_rsp_data      fetched instruction word
//   pipe_stall         decode cannot accept this cycle
//   pipe_flush         redirect to flush_pc, discard older work
//   flush_pc           redirect target
//   instr, instr_valid, instr_tag  head entry presented to decode
module ifu_fetch_buf #(
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     INSTR_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      flush_pc,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]      pc;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     drop;
  logic [CNT_W-1:0]     outstanding_nxt;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W-1:0]     pend_wr_ptr, pend_rd_ptr;

  logic [INSTR_LEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0]      buf_tag   [DEPTH];
  logic [XLEN-1:0]      pend_pc   [DEPTH];

  logic credit_ok;
  logic accept;
  logic rsp_drop;
  logic rsp_keep;
  logic push;
  logic pop;

  // Request credit: buffered entries plus in-flight requests never exceed DEPTH
  always_comb begin
    credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
    imem_req_valid  = rst_n & ~pipe_flush & credit_ok;
    imem_req_addr   = pc;
    accept          = imem_req_valid & imem_req_ready;
    rsp_drop        = imem_rsp_valid & (drop != '0);
    rsp_keep        = imem_rsp_valid & (drop == '0);
    push            = rst_n & rsp_keep & ~pipe_flush;
    instr_valid     = (count != '0);
    pop             = instr_valid & ~pipe_stall & ~pipe_flush;
    instr           = instr_valid ? buf_instr[rd_ptr] : '0;
    instr_tag       = instr_valid ? buf_tag[rd_ptr]   : '0;
    outstanding_nxt = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
  end

  // Control state: PC, occupancy, in-flight and drop counters, pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pend_wr_ptr <= '0;
      pend_rd_ptr <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (pipe_flush) begin
        // Everything still in flight after this cycle's response is stale
        pc          <= flush_pc;
        count       <= '0;
        drop        <= outstanding_nxt;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        pend_wr_ptr <= '0;
        pend_rd_ptr <= '0;
      end else begin
        if (accept) begin
          pc          <= pc + XLEN'(4);
          pend_wr_ptr <= pend_wr_ptr + PTR_W'(1);
        end
        if (rsp_drop) drop <= drop - CNT_W'(1);
        if (rsp_keep) pend_rd_ptr <= pend_rd_ptr + PTR_W'(1);
        if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage arrays need no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (accept) pend_pc[pend_wr_ptr] <= pc;
    if (push) begin
      buf_instr[wr_ptr] <= imem_rsp_data;
      buf_tag[wr_ptr]   <= pend_pc[pend_rd_ptr];
    end
  end

  // The credit rule must make a push into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: doc/ifu_fetch_buf.md
Name: ifu_fetch_buf

Overview:
Instruction fetch front end that produces the `instr` / `instr_valid` / `instr_tag` stream consumed by the decode stage.
- Generates sequential PCs and issues requests to instruction memory.
- Buffers responses in a small in-order FIFO and presents the head entry to decode.
- Honours `pipe_stall` (hold) and `pipe_flush` (redirect to `flush_pc`, discard all older work).

Parameters:
- DEPTH, 4, FIFO entries; also caps FIFO occupancy plus outstanding requests. Power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  XLEN  fetch address (PC)
- imem_rsp_valid  in  1  response valid; in order, latency ≥1 cycle
- imem_rsp_data  in  INSTR_LEN  fetched instruction word
- pipe_stall  in  1  decode cannot accept this cycle
- pipe_flush  in  1  redirect; priority over `pipe_stall`
- flush_pc  in  XLEN  redirect target, valid with `pipe_flush`
- instr  out  INSTR_LEN  head instruction to decode
- instr_valid  out  1  head valid
- instr_tag  out  XLEN  PC of `instr`

Behaviour:
- Reset (rst_n low at posedge): pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
  - While reset is held: `imem_req_valid`=0, `instr_valid`=0, `instr`=0, `instr_tag`=0.
  - Any response arriving during reset is ignored.
- Request issue:
  - `imem_req_valid` = ~pipe_flush & (fifo_count + outstanding < DEPTH).
  - `imem_req_addr` = pc.
  - Accept = valid & ready. On accept: pc += 4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0), outstanding += 1.
  - Request is non-sticky: valid may drop without acceptance (flush, credit loss).
- A tag FIFO of issued PCs (depth DEPTH) pairs each response with its address.
- Response handling:
  - If drop>0: the response is discarded, drop -= 1.
  - Otherwise {instr=rsp_data, tag=issued PC} is pushed.
  - In both cases outstanding -= 1.
  - The credit rule guarantees no push when full. An overflow push is an assertion failure.
- Output:
  - `instr_valid` = FIFO non-empty. `instr` / `instr_tag` = head entry (show-ahead).
  - No bypass: a response at cycle N is visible at cycle N+1 at the earliest.
- Pop: instr_valid & ~pipe_stall & ~pipe_flush.
  - Head is held stable while stalled.
  - Simultaneous push and pop is allowed; count is unchanged.
- Flush (pipe_flush=1 at posedge):
  - FIFO and tag FIFO are cleared.
  - pc = flush_pc.
  - drop = outstanding after this cycle's response (responses already discarded this cycle are not counted twice).
  - No request is issued in the flush cycle. The first request to flush_pc can go out the next cycle.
  - Flush while drop>0 is legal: drop = all outstanding requests.
- Stall:
  - Issue continues until credits are exhausted (count+outstanding=DEPTH), then stops.
  - Issue resumes the cycle after a pop frees a credit.
- Counter widths: $clog2(DEPTH+1). Counters never wrap.
- Latency: with a memory that is always ready and has 1-cycle latency, the first `instr_valid` appears 2 cycles after reset release. Steady-state throughput is 1 instruction/cycle.
- `flush_pc` low bits are not checked; alignment is the redirect source's responsibility.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning data=addr^32'hA5A5_0000 → addresses 0,4,8,… issued back-to-back. `instr_tag` sequence 0,4,8 with matching data. First `instr_valid` at cycle 2 after reset release.
- Stall held 10 cycles, DEPTH=4 → exactly 4 requests outstanding/buffered, `imem_req_valid`=0 thereafter. Head stays tag 0. On release, tags 0,4,8,12 are delivered on consecutive cycles and issue resumes.
- 3-cycle memory latency, flush with flush_pc=32'h100 while 2 requests are in flight → both stale responses are dropped, `instr_valid` stays 0 until the response for 0x100 arrives. First tag after flush = 0x100.
- Flush and stall asserted together with FIFO holding 3 entries → next cycle FIFO is empty, pc=flush_pc, no pop occurred, no stale instruction reaches the output.
- RESET_PC=32'hFFFF_FFF8 → tags FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n asserted mid-stream with 2 requests outstanding and the FIFO partially full → all outputs 0 at the next cycle. After release, fetch restarts at RESET_PC. Late responses that arrive during reset are ignored.
